// File: rtl/huff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huff_pkg
//  Description : Shared sizes, FSM states and code-placement helper for the
//                Huffman bit packer.
//  Revision    : 1.0
// ============================================================================
package huff_pkg;

    localparam int NSYM   = 10;
    localparam int SYM_W  = 4;
    localparam int CODE_W = 9;
    localparam int LEN_W  = 4;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = 32;
    localparam int FILL_W = 6;
    localparam int BITS_W = 5;

    localparam logic [FILL_W-1:0] FILL_OUT   = FILL_W'(OUT_W);
    localparam logic [FILL_W:0]   SHIFT_BASE = (FILL_W+1)'(ACC_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Place a right-aligned code directly below the bits already in the accumulator.
    function automatic logic [ACC_W-1:0] place_code(
        input logic [CODE_W-1:0] code,
        input logic [FILL_W-1:0] fill,
        input logic [LEN_W-1:0]  len
    );
        logic [FILL_W:0] w_sh;
        w_sh = SHIFT_BASE - {1'b0, fill} - {{(FILL_W+1-LEN_W){1'b0}}, len};
        return {{(ACC_W-CODE_W){1'b0}}, code} << w_sh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/huff_bitpack_if.sv
`default_nettype none
// ============================================================================
//  Module      : huff_bitpack_if
//  Description : Table handshake, symbol stream and word stream of the packer.
//  Revision    : 1.0
// ============================================================================
interface huff_bitpack_if;
    import huff_pkg::*;

    logic                    tbl_req;
    logic                    tbl_ack;
    logic [NSYM*CODE_W-1:0]  tbl_code;
    logic [NSYM*LEN_W-1:0]   tbl_len;
    logic                    sym_valid;
    logic [SYM_W-1:0]        sym_in;
    logic                    sym_last;
    logic                    sym_ready;
    logic                    word_valid;
    logic [OUT_W-1:0]        word_out;
    logic                    word_last;
    logic [BITS_W-1:0]       word_bits;
    logic                    word_ready;
    logic                    done;
    logic                    err;

    modport slave (
        input  tbl_req, tbl_code, tbl_len, sym_valid, sym_in, sym_last, word_ready,
        output tbl_ack, sym_ready, word_valid, word_out, word_last, word_bits, done, err
    );

    modport master (
        output tbl_req, tbl_code, tbl_len, sym_valid, sym_in, sym_last, word_ready,
        input  tbl_ack, sym_ready, word_valid, word_out, word_last, word_bits, done, err
    );

endinterface
`default_nettype wire

// File: rtl/huff_code_lut.sv
`default_nettype none
// ============================================================================
//  Module      : huff_code_lut
//  Description : Latched code table with combinational symbol lookup.
//  Revision    : 1.0
// ============================================================================
module huff_code_lut
    import huff_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [NSYM*CODE_W-1:0]  tbl_code,
    input  logic [NSYM*LEN_W-1:0]   tbl_len,
    input  logic [SYM_W-1:0]        sym,
    output logic [CODE_W-1:0]       code,
    output logic [LEN_W-1:0]        len,
    output logic                    invalid
);

    logic [NSYM*CODE_W-1:0] r_code;
    logic [NSYM*LEN_W-1:0]  r_len;
    logic [CODE_W-1:0]      w_code_arr [NSYM];
    logic [LEN_W-1:0]       w_len_arr  [NSYM];
    logic                   w_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code <= '0;
            r_len  <= '0;
        end else if (load) begin
            r_code <= tbl_code;
            r_len  <= tbl_len;
        end
    end

    for (genvar gi = 0; gi < NSYM; gi++) begin : g_unpack
        assign w_code_arr[gi] = r_code[gi*CODE_W +: CODE_W];
        assign w_len_arr[gi]  = r_len[gi*LEN_W +: LEN_W];
    end

    // Symbols beyond the table and zero-length entries both count as invalid.
    always_comb begin
        code  = '0;
        len   = '0;
        w_hit = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            if (sym == SYM_W'(i)) begin
                code  = w_code_arr[i];
                len   = w_len_arr[i];
                w_hit = 1'b1;
            end
        end
        invalid = !w_hit || (len == '0);
    end

endmodule
`default_nettype wire

// File: rtl/huff_bitpack.sv
`default_nettype none
// ============================================================================
//  Module      : huff_bitpack
//  Description : Latches a Huffman table, packs symbol codes MSB-first into
//                OUT_W-bit words with a zero-padded, length-tagged last word.
//  Revision    : 1.0
// ============================================================================
module huff_bitpack
    import huff_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    huff_bitpack_if.slave bus
);

    state_t              r_state, w_state_nxt;
    logic [ACC_W-1:0]    r_acc, w_acc_nxt;
    logic [FILL_W-1:0]   r_fill, w_fill_nxt;
    logic                r_err, w_err_nxt;
    logic                r_done, w_done_nxt;
    logic                w_load;
    logic                w_sym_ready;
    logic                w_word_valid;
    logic                w_word_last;
    logic [BITS_W-1:0]   w_word_bits;
    logic [CODE_W-1:0]   w_code;
    logic [LEN_W-1:0]    w_len;
    logic                w_invalid;

    huff_code_lut u_lut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .tbl_code (bus.tbl_code),
        .tbl_len  (bus.tbl_len),
        .sym      (bus.sym_in),
        .code     (w_code),
        .len      (w_len),
        .invalid  (w_invalid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_fill  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_fill  <= w_fill_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_fill_nxt   = r_fill;
        w_err_nxt    = r_err;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_sym_ready  = 1'b0;
        w_word_valid = 1'b0;
        w_word_last  = 1'b0;
        w_word_bits  = '0;

        case (r_state)
            IDLE: begin
                if (bus.tbl_req) begin
                    w_load      = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ACK;
                end
            end

            ACK: begin
                if (!bus.tbl_req) begin
                    w_state_nxt = RUN;
                end
            end

            RUN: begin
                // A full word blocks new symbols, so the two handshakes never overlap.
                w_sym_ready  = (r_fill < FILL_OUT);
                w_word_valid = !w_sym_ready;
                if (w_word_valid) begin
                    w_word_bits = BITS_W'(OUT_W);
                end
                if (w_sym_ready && bus.sym_valid) begin
                    if (w_invalid) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_acc_nxt  = r_acc | place_code(w_code, r_fill, w_len);
                        w_fill_nxt = r_fill + FILL_W'(w_len);
                    end
                    if (bus.sym_last) begin
                        w_state_nxt = FLUSH;
                    end
                end else if (w_word_valid && bus.word_ready) begin
                    w_acc_nxt  = r_acc << OUT_W;
                    w_fill_nxt = r_fill - FILL_OUT;
                end
            end

            FLUSH: begin
                if (r_fill == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_fill > FILL_OUT) begin
                    w_word_valid = 1'b1;
                    w_word_bits  = BITS_W'(OUT_W);
                    if (bus.word_ready) begin
                        w_acc_nxt  = r_acc << OUT_W;
                        w_fill_nxt = r_fill - FILL_OUT;
                    end
                end else begin
                    w_word_valid = 1'b1;
                    w_word_last  = 1'b1;
                    w_word_bits  = BITS_W'(r_fill);
                    if (bus.word_ready) begin
                        w_acc_nxt   = '0;
                        w_fill_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.tbl_ack    = (r_state == ACK);
    assign bus.sym_ready  = w_sym_ready;
    assign bus.word_valid = w_word_valid;
    assign bus.word_out   = r_acc[ACC_W-1 -: OUT_W];
    assign bus.word_last  = w_word_last;
    assign bus.word_bits  = w_word_bits;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_huff_bitpack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huff_bitpack
//  Description : Self-checking bench for huff_bitpack.
//  Revision    : 1.0
// ============================================================================
module tb_huff_bitpack;
    import huff_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    huff_bitpack_if bus ();

    huff_bitpack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] w;
        logic        last;
        logic [4:0]  bits;
    } word_t;

    typedef struct {
        int          n;
        int          syms [12];
        int          exp_n;
        logic [15:0] exp_first;
        int          exp_bits;
        logic        exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rdy_mode = 0;
    int          t_len  [NSYM] = '{2, 2, 3, 3, 3, 4, 5, 6, 7, 7};
    logic [8:0]  t_code [NSYM] = '{9'd0, 9'd1, 9'd4, 9'd5, 9'd6, 9'd14, 9'd30, 9'd62, 9'd126, 9'd127};
    word_t       got [$];
    word_t       exp_q [$];
    int          stim [$];
    logic        exp_err;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: concatenate code bits per symbol, then slice into 16-bit words.
    function automatic void model();
        bit q [$];
        exp_q.delete();
        exp_err = 1'b0;
        foreach (stim[k]) begin
            int s = stim[k];
            if (s < NSYM && t_len[s] != 0) begin
                for (int b = t_len[s] - 1; b >= 0; b--) q.push_back(t_code[s][b]);
            end else begin
                exp_err = 1'b1;
            end
        end
        while (q.size() > 0) begin
            word_t x;
            int    n;
            n = (q.size() > 16) ? 16 : q.size();
            x.w = '0;
            for (int b = 0; b < n; b++) x.w[15-b] = q.pop_front();
            x.bits = 5'(n);
            x.last = (q.size() == 0);
            exp_q.push_back(x);
        end
    endfunction

    initial begin
        bus.word_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.word_ready = 1'b1;
                1:       bus.word_ready = ~bus.word_ready;
                default: bus.word_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Word capture plus hold-while-stalled and handshake exclusivity checks.
    logic        p_pend = 1'b0;
    logic [15:0] p_w;
    logic        p_l;
    logic [4:0]  p_b;
    always @(negedge clk) begin
        if (rst_n) begin
            if (p_pend) begin
                check("hold_valid", 32'(bus.word_valid), 32'd1);
                check("hold_word",  32'(bus.word_out),   32'(p_w));
                check("hold_last",  32'(bus.word_last),  32'(p_l));
                check("hold_bits",  32'(bus.word_bits),  32'(p_b));
            end
            if (bus.word_valid) check("ready_excl", 32'(bus.sym_ready), 32'd0);
            if (bus.word_valid && bus.word_ready)
                got.push_back('{bus.word_out, bus.word_last, bus.word_bits});
            p_pend = bus.word_valid && !bus.word_ready;
            p_w = bus.word_out;
            p_l = bus.word_last;
            p_b = bus.word_bits;
        end else begin
            p_pend = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic load_table();
        int k = 0;
        bus.tbl_req = 1'b1;
        do begin @(negedge clk); k++; end while (!bus.tbl_ack && k < 50);
        check("ack_rise", 32'(bus.tbl_ack), 32'd1);
        cyc();
        bus.tbl_req = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (bus.tbl_ack && k < 50);
        check("ack_fall", 32'(bus.tbl_ack), 32'd0);
        cyc();
    endtask

    task automatic send(input int mode, input bit with_last);
        rdy_mode = mode;
        for (int k = 0; k < stim.size(); k++) begin
            int tries = 0;
            bit acc;
            bus.sym_valid = 1'b1;
            bus.sym_in    = SYM_W'(stim[k]);
            bus.sym_last  = with_last && (k == stim.size() - 1);
            do begin
                @(negedge clk);
                acc = bus.sym_ready;
                tries++;
                cyc();
            end while (!acc && tries < 200);
            if (!acc) check("sym_accept_timeout", 32'd0, 32'd1);
        end
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
    endtask

    task automatic finish_block(input string name);
        int k = 0;
        model();
        do begin @(negedge clk); k++; end while (!bus.done && k < 300);
        check({name, "_done"}, 32'(bus.done), 32'd1);
        check({name, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i),    32'(got[i].w),    32'(exp_q[i].w));
            check($sformatf("%s_last%0d", name, i), 32'(got[i].last), 32'(exp_q[i].last));
            check($sformatf("%s_bits%0d", name, i), 32'(got[i].bits), 32'(exp_q[i].bits));
        end
        check({name, "_err"}, 32'(bus.err), 32'(exp_err));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({name, "_idle_no_ready"}, 32'(bus.sym_ready), 32'd0);
        cyc();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"},   32'(bus.tbl_ack),    32'd0);
        check({name, "_srdy"},  32'(bus.sym_ready),  32'd0);
        check({name, "_wval"},  32'(bus.word_valid), 32'd0);
        check({name, "_word"},  32'(bus.word_out),   32'd0);
        check({name, "_wlast"}, 32'(bus.word_last),  32'd0);
        check({name, "_wbits"}, 32'(bus.word_bits),  32'd0);
        check({name, "_done"},  32'(bus.done),       32'd0);
        check({name, "_err"},   32'(bus.err),        32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.tbl_req   = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_in    = '0;
        bus.sym_last  = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            bus.tbl_code[i*CODE_W +: CODE_W] = t_code[i];
            bus.tbl_len[i*LEN_W +: LEN_W]    = LEN_W'(t_len[i]);
        end
        vecs[0] = '{5, '{0,1,2,3,4,0,0,0,0,0,0,0}, 1, 16'h1970, 13, 1'b0};
        vecs[1] = '{8, '{1,1,1,1,1,1,1,1,0,0,0,0}, 1, 16'h5555, 16, 1'b0};
        vecs[2] = '{2, '{8,9,0,0,0,0,0,0,0,0,0,0}, 1, 16'hFDFC, 14, 1'b0};
        vecs[3] = '{1, '{12,0,0,0,0,0,0,0,0,0,0,0}, 0, 16'h0000, 0, 1'b1};
        vecs[4] = '{6, '{0,1,12,2,3,4,0,0,0,0,0,0}, 1, 16'h1970, 13, 1'b1};
        vecs[5] = '{1, '{0,0,0,0,0,0,0,0,0,0,0,0}, 1, 16'h0000, 2, 1'b0};
        vecs[6] = '{2, '{6,7,0,0,0,0,0,0,0,0,0,0}, 1, 16'hF7C0, 11, 1'b0};

        cyc(); cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        cyc();

        // Table handshake: request held three cycles.
        bus.tbl_req = 1'b1;
        @(negedge clk); check("hs_c0_ack", 32'(bus.tbl_ack), 32'd0);
        cyc(); @(negedge clk); check("hs_c1_ack", 32'(bus.tbl_ack), 32'd1);
        cyc(); @(negedge clk); check("hs_c2_ack", 32'(bus.tbl_ack), 32'd1);
        cyc(); bus.tbl_req = 1'b0;
        @(negedge clk); check("hs_c3_ack", 32'(bus.tbl_ack), 32'd1);
        cyc(); @(negedge clk);
        check("hs_c4_ack", 32'(bus.tbl_ack), 32'd0);
        check("hs_c4_srdy", 32'(bus.sym_ready), 32'd1);
        cyc();

        // Directed vectors; the first reuses the table loaded above.
        for (int v = 0; v < 7; v++) begin
            if (v != 0) begin
                load_table();
                check($sformatf("v%0d_err_cleared", v), 32'(bus.err), 32'd0);
            end
            got.delete();
            stim.delete();
            for (int k = 0; k < vecs[v].n; k++) stim.push_back(vecs[v].syms[k]);
            send(0, 1'b1);
            finish_block($sformatf("vec%0d", v));
            check($sformatf("vec%0d_tbl_n", v), 32'(got.size()), 32'(vecs[v].exp_n));
            if (got.size() > 0 && vecs[v].exp_n > 0) begin
                check($sformatf("vec%0d_tbl_word", v), 32'(got[got.size()-1].w), 32'(vecs[v].exp_first));
                check($sformatf("vec%0d_tbl_bits", v), 32'(got[got.size()-1].bits), 32'(vecs[v].exp_bits));
            end
            check($sformatf("vec%0d_tbl_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
        end

        // Backpressure: nine s9 with word_ready toggling.
        load_table();
        got.delete();
        stim.delete();
        for (int k = 0; k < 9; k++) stim.push_back(9);
        send(1, 1'b1);
        finish_block("bp");
        check("bp_n", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("bp_w0", 32'(got[0].w), 32'hFFFF);
            check("bp_w2", 32'(got[2].w), 32'hFFFF);
            check("bp_w3", 32'(got[3].w), 32'hFFFE);
            check("bp_b3", 32'(got[3].bits), 32'd15);
        end

        // Reset mid-stream with err set, then a clean block.
        load_table();
        got.delete();
        stim.delete();
        stim = '{0, 12, 1};
        send(0, 1'b0);
        @(negedge clk); check("pre_rst_err", 32'(bus.err), 32'd1);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        cyc();
        load_table();
        got.delete();
        stim = '{0, 1, 2, 3, 4};
        send(0, 1'b1);
        finish_block("post_rst");
        if (got.size() > 0) check("post_rst_word", 32'(got[0].w), 32'h1970);

        // Random blocks against the reference model under random backpressure.
        for (int b = 0; b < 25; b++) begin
            int n;
            load_table();
            got.delete();
            stim.delete();
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++)
                stim.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            send(2, 1'b1);
            finish_block($sformatf("rnd%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
